seg7_sequence_monitor: RTL and testbench

Receive-side checker for the 6-state counter display. Samples the 7-segment bus {A,B,C,D,E,F,G} driven by the counter FSM and decodes each pattern back to a digit 0..5. Confirms the sequence obeys the counter's protocol: on each sample, hold or advance by one modulo 6. Reports lock status, wrap events and protocol errors to the board-level status/LED logic.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_decode.sv | 24 ++
 rtl/seg7_sequence_monitor.sv | 161 ++++++++++++++++
 tb/tb_seg7_sequence_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment patterns and digit helper for the 7-segment monitor
package seg7_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  // Segment order {A,B,C,D,E,F,G}, bit 6 = A, active-high
  localparam logic [6:0] SEG_DIG0 = 7'b1111110;
  localparam logic [6:0] SEG_DIG1 = 7'b0110000;
  localparam logic [6:0] SEG_DIG2 = 7'b1101101;
  localparam logic [6:0] SEG_DIG3 = 7'b1111001;
  localparam logic [6:0] SEG_DIG4 = 7'b0110011;
  localparam logic [6:0] SEG_DIG5 = 7'b1011011;

  function automatic logic [2:0] next_digit(input logic [2:0] p);
    return (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational segment-pattern to digit 0..5 decoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [2:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 3'd0;
    valid = 1'b1;
    case (seg)
      SEG_DIG0: digit = 3'd0;
      SEG_DIG1: digit = 3'd1;
      SEG_DIG2: digit = 3'd2;
      SEG_DIG3: digit = 3'd3;
      SEG_DIG4: digit = 3'd4;
      SEG_DIG5: digit = 3'd5;
      default:  valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_sequence_monitor.sv
// rtl/seg7_sequence_monitor.sv - checks the sampled 7-segment digit stream holds or advances by one mod 6
module seg7_sequence_monitor
  import seg7_pkg::*;
#(
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned LOCK_ADV   = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SEG_VALID,
  input  logic [6:0]       SEG,
  input  logic             CLR_CNT,
  output logic [2:0]       DIGIT,
  output logic             DIGIT_VALID,
  output logic             LOCKED,
  output logic             WRAP,
  output logic             ERR,
  output logic             BAD_PAT,
  output logic [CNT_W-1:0] WRAP_COUNT,
  output logic [CNT_W-1:0] ERR_COUNT
);

  localparam logic [3:0] LOCK_ADV_W = 4'(LOCK_ADV);

  logic [6:0] seg_pol;
  logic [2:0] dec_digit;
  logic       dec_valid;

  assign seg_pol = ACTIVE_LOW ? ~SEG : SEG;

  seg7_decode u_decode (
    .seg   (seg_pol),
    .digit (dec_digit),
    .valid (dec_valid)
  );

  mon_state_t       state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [2:0]       digit_q, digit_d;
  logic             dv_q, dv_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             bad_q, bad_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       is_hold, is_adv;
  logic [3:0] run_inc;

  assign is_hold = (dec_digit == digit_q);
  assign is_adv  = (dec_digit == next_digit(digit_q));
  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    digit_d = digit_q;
    dv_d    = dv_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    bad_d   = 1'b0;
    case (state_q)
      HUNT: if (SEG_VALID) begin
        if (dec_valid) begin
          digit_d = dec_digit;
          dv_d    = 1'b1;
          run_d   = 4'd0;
          state_d = TRACK;
        end else begin
          bad_d = 1'b1;
          dv_d  = 1'b0;
        end
      end
      TRACK: if (SEG_VALID) begin
        if (!dec_valid) begin
          bad_d   = 1'b1;
          dv_d    = 1'b0;
          state_d = HUNT;
        end else if (is_hold) begin
          digit_d = dec_digit;
        end else if (is_adv) begin
          digit_d = dec_digit;
          run_d   = run_inc;
          if (run_inc == LOCK_ADV_W) state_d = seg7_pkg::LOCKED;
        end else begin
          digit_d = dec_digit;
          run_d   = 4'd0;
        end
      end
      seg7_pkg::LOCKED: if (SEG_VALID) begin
        if (!dec_valid) begin
          err_d   = 1'b1;
          bad_d   = 1'b1;
          dv_d    = 1'b0;
          state_d = HUNT;
        end else if (is_hold || is_adv) begin
          digit_d = dec_digit;
          wrap_d  = is_adv && (digit_q == 3'd5);
        end else begin
          err_d   = 1'b1;
          digit_d = dec_digit;
          run_d   = 4'd0;
          state_d = TRACK;
        end
      end
      default: begin
        state_d = HUNT;
        run_d   = 4'd0;
        dv_d    = 1'b0;
      end
    endcase
  end

  // A clear wins over a same-edge event; the event pulse itself is unaffected
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (CLR_CNT) begin
      wrap_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      if (wrap_d) wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
      if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= HUNT;
      run_q      <= 4'd0;
      digit_q    <= 3'd0;
      dv_q       <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      bad_q      <= 1'b0;
      wrap_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      digit_q    <= digit_d;
      dv_q       <= dv_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      bad_q      <= bad_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign DIGIT       = digit_q;
  assign DIGIT_VALID = dv_q;
  assign LOCKED      = (state_q == seg7_pkg::LOCKED);
  assign WRAP        = wrap_q;
  assign ERR         = err_q;
  assign BAD_PAT     = bad_q;
  assign WRAP_COUNT  = wrap_cnt_q;
  assign ERR_COUNT   = err_cnt_q;

endmodule

// File: tb/tb_seg7_sequence_monitor.sv
// tb/tb_seg7_sequence_monitor.sv - bench for seg7_sequence_monitor, active-high and active-low instances
module tb_seg7_sequence_monitor;

  localparam int LOCK_N = 3;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEG_VALID = 1'b0;
  logic [6:0] SEG = 7'd0;
  logic       CLR_CNT = 1'b0;
  logic [6:0] seg_al;

  logic [2:0] digit_h, digit_l;
  logic       dv_h, dv_l, lk_h, lk_l, wrap_h, wrap_l, err_h, err_l, bad_h, bad_l;
  logic [7:0] wcnt_h, wcnt_l, ecnt_h, ecnt_l;

  int checks = 0;
  int errors = 0;

  logic [6:0] pat [6] = '{7'b1111110, 7'b0110000, 7'b1101101,
                          7'b1111001, 7'b0110011, 7'b1011011};

  // Reference model: digit stream history rather than an explicit state machine
  int m_digit, m_dv, m_seeded, m_adv, m_wcnt, m_ecnt;
  bit m_wrap, m_err, m_bad;

  assign seg_al = ~SEG;

  always #5 CLK = ~CLK;

  seg7_sequence_monitor #(.ACTIVE_LOW(1'b0), .LOCK_ADV(LOCK_N), .CNT_W(8)) dut_h (
    .CLK(CLK), .RESET(RESET), .SEG_VALID(SEG_VALID), .SEG(SEG), .CLR_CNT(CLR_CNT),
    .DIGIT(digit_h), .DIGIT_VALID(dv_h), .LOCKED(lk_h), .WRAP(wrap_h), .ERR(err_h),
    .BAD_PAT(bad_h), .WRAP_COUNT(wcnt_h), .ERR_COUNT(ecnt_h)
  );

  seg7_sequence_monitor #(.ACTIVE_LOW(1'b1), .LOCK_ADV(LOCK_N), .CNT_W(8)) dut_l (
    .CLK(CLK), .RESET(RESET), .SEG_VALID(SEG_VALID), .SEG(seg_al), .CLR_CNT(CLR_CNT),
    .DIGIT(digit_l), .DIGIT_VALID(dv_l), .LOCKED(lk_l), .WRAP(wrap_l), .ERR(err_l),
    .BAD_PAT(bad_l), .WRAP_COUNT(wcnt_l), .ERR_COUNT(ecnt_l)
  );

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 6; i++) if (pat[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_digit = 0; m_dv = 0; m_seeded = 0; m_adv = 0;
    m_wcnt = 0; m_ecnt = 0; m_wrap = 0; m_err = 0; m_bad = 0;
  endtask

  function automatic int m_locked();
    return (m_seeded != 0 && m_adv >= LOCK_N) ? 1 : 0;
  endfunction

  task automatic model_step(input bit v, input logic [6:0] s, input bit c);
    int d;
    int lk;
    lk = m_locked();
    m_wrap = 0; m_err = 0; m_bad = 0;
    if (v) begin
      d = decode(s);
      if (d < 0) begin
        m_bad = 1;
        if (lk != 0) begin m_err = 1; if (m_ecnt < 255) m_ecnt++; end
        m_seeded = 0; m_dv = 0;
      end else if (m_seeded == 0) begin
        m_seeded = 1; m_digit = d; m_dv = 1; m_adv = 0;
      end else if (d == m_digit) begin
        m_digit = d;
      end else if (d == (m_digit + 1) % 6) begin
        if (lk != 0 && m_digit == 5) begin m_wrap = 1; m_wcnt = (m_wcnt + 1) % 256; end
        m_digit = d;
        if (m_adv < 1000) m_adv++;
      end else begin
        if (lk != 0) begin m_err = 1; if (m_ecnt < 255) m_ecnt++; end
        m_digit = d; m_adv = 0;
      end
    end
    if (c) begin m_wcnt = 0; m_ecnt = 0; end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".digit_h"}, 8'(digit_h), 8'(m_digit));
    chk({tag, ".dv_h"},    8'(dv_h),    8'(m_dv));
    chk({tag, ".lock_h"},  8'(lk_h),    8'(m_locked()));
    chk({tag, ".wrap_h"},  8'(wrap_h),  8'(m_wrap));
    chk({tag, ".err_h"},   8'(err_h),   8'(m_err));
    chk({tag, ".bad_h"},   8'(bad_h),   8'(m_bad));
    chk({tag, ".wcnt_h"},  wcnt_h,      8'(m_wcnt));
    chk({tag, ".ecnt_h"},  ecnt_h,      8'(m_ecnt));
    chk({tag, ".digit_l"}, 8'(digit_l), 8'(m_digit));
    chk({tag, ".dv_l"},    8'(dv_l),    8'(m_dv));
    chk({tag, ".lock_l"},  8'(lk_l),    8'(m_locked()));
    chk({tag, ".wrap_l"},  8'(wrap_l),  8'(m_wrap));
    chk({tag, ".err_l"},   8'(err_l),   8'(m_err));
    chk({tag, ".bad_l"},   8'(bad_l),   8'(m_bad));
    chk({tag, ".wcnt_l"},  wcnt_l,      8'(m_wcnt));
    chk({tag, ".ecnt_l"},  ecnt_l,      8'(m_ecnt));
  endtask

  task automatic cycle(input string tag, input bit v, input logic [6:0] s, input bit c);
    SEG_VALID = v; SEG = s; CLR_CNT = c;
    @(posedge CLK);
    model_step(v, s, c);
    #1;
    check_all(tag);
  endtask

  task automatic samp(input string tag, input int d, input bit c = 1'b0);
    cycle(tag, 1'b1, pat[d], c);
  endtask

  initial begin
    int kind;
    int d;
    logic [6:0] s;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    #2 RESET = 1'b0;

    // Lock-in after three advances
    for (int i = 0; i < 4; i++) samp("lockin", i);
    chk("lockin.locked", 8'(lk_h), 8'd1);
    chk("lockin.digit", 8'(digit_h), 8'd3);

    // Hold then wrap while locked
    samp("wrap", 4); samp("wrap", 5); samp("wrap", 5); samp("wrap", 0);
    chk("wrap.count", wcnt_h, 8'd1);

    // Illegal jump 2 -> 4 while locked
    samp("illegal", 1); samp("illegal", 2); samp("illegal", 4);
    chk("illegal.err", 8'(err_h), 8'd1);

    // Relock, then a blank pattern, then recovery
    samp("blank", 5); samp("blank", 0); samp("blank", 1);
    cycle("blank", 1'b1, 7'b0000000, 1'b0);
    chk("blank.bad", 8'(bad_h), 8'd1);
    samp("blank.rec", 1);

    // Full lap 0..5,0 including idle gaps
    for (int i = 0; i < 7; i++) begin
      samp("lap", i % 6);
      cycle("lap.idle", 1'b0, $urandom_range(0, 127), 1'b0);
    end

    // Randomised stream
    for (int i = 0; i < 600; i++) begin
      kind = $urandom_range(0, 9);
      d = (m_seeded != 0) ? m_digit : $urandom_range(0, 5);
      if (kind <= 4) s = pat[(d + 1) % 6];
      else if (kind <= 6) s = pat[d];
      else if (kind == 7) s = pat[$urandom_range(0, 5)];
      else s = 7'($urandom_range(0, 127));
      cycle("rand", kind != 9, s, $urandom_range(0, 39) == 0);
    end

    // Error counter saturation, then clear on the same edge as an error
    samp("sat.clr", 0, 1'b1);
    for (int i = 0; i < 258; i++) begin
      for (int k = 0; k < LOCK_N; k++) samp("sat", (m_digit + 1) % 6);
      samp("sat.err", (m_digit + 3) % 6);
    end
    chk("sat.ecnt", ecnt_h, 8'hFF);
    for (int k = 0; k < LOCK_N; k++) samp("clrerr", (m_digit + 1) % 6);
    samp("clrerr", (m_digit + 3) % 6, 1'b1);
    chk("clrerr.err", 8'(err_h), 8'd1);
    chk("clrerr.ecnt", ecnt_h, 8'd0);

    // Asynchronous reset mid-stream
    samp("midrst", (m_digit + 1) % 6);
    samp("midrst", (m_digit + 1) % 6);
    #2 RESET = 1'b1;
    model_reset();
    #1 check_all("midrst.async");
    @(posedge CLK);
    #1 check_all("midrst.held");
    #2 RESET = 1'b0;
    samp("midrst.after", 4);
    samp("midrst.after", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
